// File: rtl/apb_mem_slave.sv
// APB memory-mapped slave: DEPTH words of DATA_WIDTH bits with programmable wait states and
// out-of-range error signalling. Define APB_MEM_SLAVE_PSTRB_EN to add the PSTRB byte-lane port.
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_MEM_SLAVE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [DATA_WIDTH-1:0]   PRDATA
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int BA  = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - BA;
    localparam int MIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  oob_q, oob_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef APB_MEM_SLAVE_PSTRB_EN
    logic [NB-1:0]         strb_q, strb_d;
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [IW-1:0]         paddr_idx;
    logic                  paddr_oob;
    logic [IW-1:0]         cur_idx;
    logic                  cur_oob;
    logic                  cur_write;
    logic                  go_done;

    assign paddr_idx = PADDR[ADDR_WIDTH-1:BA];
    assign paddr_oob = (32'(paddr_idx) >= 32'(DEPTH));

    if (BA > 0) begin : g_lsb
        logic addr_lsb_unused;
        assign addr_lsb_unused = ^PADDR[BA-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        slverr_d  = slverr_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        oob_d     = oob_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
`ifdef APB_MEM_SLAVE_PSTRB_EN
        strb_d    = strb_q;
`endif
        mem_we    = 1'b0;
        go_done   = 1'b0;
        // With zero wait states DONE is entered straight from setup, before the capture lands.
        cur_idx   = (state_q == S_IDLE) ? paddr_idx : idx_q;
        cur_oob   = (state_q == S_IDLE) ? paddr_oob : oob_q;
        cur_write = (state_q == S_IDLE) ? PWRITE    : write_q;

        mem_wdata = wdata_q;
`ifdef APB_MEM_SLAVE_PSTRB_EN
        for (int unsigned i = 0; i < NB; i++) begin
            if (!strb_q[i]) mem_wdata[8*i +: 8] = mem_q[idx_q[MIW-1:0]][8*i +: 8];
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    idx_d   = paddr_idx;
                    oob_d   = paddr_oob;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
`ifdef APB_MEM_SLAVE_PSTRB_EN
                    strb_d  = PSTRB;
`endif
                    if (WAIT_CYCLES == 0) begin
                        go_done = 1'b1;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) go_done = 1'b1;
                end
            end
            S_DONE: begin
                mem_we   = PSEL && PENABLE && write_q && !oob_q;
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                slverr_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (go_done) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            slverr_d = cur_oob;
            if (!cur_write) rdata_d = cur_oob ? '0 : mem_q[cur_idx[MIW-1:0]];
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            idx_q    <= '0;
            oob_q    <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
`ifdef APB_MEM_SLAVE_PSTRB_EN
            strb_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            idx_q    <= idx_d;
            oob_q    <= oob_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
`ifdef APB_MEM_SLAVE_PSTRB_EN
            strb_q   <= strb_d;
`endif
        end
    end

    always_ff @(posedge PCLK) begin
        if (mem_we) mem_q[idx_q[MIW-1:0]] <= mem_wdata;
    end

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;
    assign PRDATA  = rdata_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 3 and 2 wait states) on a shared APB bus,
// checked every cycle against a transaction-level memory/timing model.
module tb_apb_mem_slave;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 64;
    localparam int ND    = 3;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          psel [ND];
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [NB-1:0] PSTRB;
    logic          pready  [ND];
    logic          pslverr [ND];
    logic [DW-1:0] prdata  [ND];

    logic          exp_ready [ND];
    logic          exp_err   [ND];
    logic [DW-1:0] exp_rdata [ND];
    logic [DW-1:0] mdl [ND][DEPTH];

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 PCLK = ~PCLK;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        apb_mem_slave #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .DEPTH      (DEPTH),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .PCLK   (PCLK),
            .PRESET (PRESET),
            .PSEL   (psel[g]),
            .PENABLE(PENABLE),
            .PWRITE (PWRITE),
            .PADDR  (PADDR),
            .PWDATA (PWDATA),
`ifdef APB_MEM_SLAVE_PSTRB_EN
            .PSTRB  (PSTRB),
`endif
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g]),
            .PRDATA (prdata[g])
        );
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (chk_on) begin
            for (int d = 0; d < ND; d++) begin
                check($sformatf("pready[%0d]", d), DW'(pready[d]), DW'(exp_ready[d]));
                if (exp_ready[d]) check($sformatf("pslverr[%0d]", d), DW'(pslverr[d]), DW'(exp_err[d]));
                check($sformatf("prdata[%0d]", d), prdata[d], exp_rdata[d]);
            end
        end
    end

    task automatic bus_idle();
        for (int i = 0; i < ND; i++) begin
            psel[i]      = 1'b0;
            exp_ready[i] = 1'b0;
        end
        PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK); #1;
            bus_idle();
        end
    endtask

    // One APB transfer on instance d. abort_at = access cycle (1..wait) at which PSEL is dropped;
    // rst_done asserts PRESET in the middle of the completion cycle.
    task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [NB-1:0] st, input int abort_at, input bit rst_done);
        int w, idx;
        bit oob;
        logic [NB-1:0] se;
        w   = wait_of(d);
        idx = int'(a[AW-1:2]);
        oob = (idx >= DEPTH);
        se  = st;
`ifndef APB_MEM_SLAVE_PSTRB_EN
        se  = '1;
`endif
        @(posedge PCLK); #1;
        bus_idle();
        psel[d] = 1'b1;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        PSTRB   = st;
        for (int k = 1; k <= w + 1; k++) begin
            @(posedge PCLK); #1;
            if (k == abort_at) begin
                psel[d] = 1'b0;
                PENABLE = 1'b0;
                return;
            end
            PENABLE = 1'b1;
            if (k == w + 1) begin
                exp_ready[d] = 1'b1;
                exp_err[d]   = oob;
                if (!wr) begin
                    if (oob) exp_rdata[d] = '0;
                    else     exp_rdata[d] = mdl[d][idx];
                end
                if (rst_done) begin
                    #1 PRESET = 1'b0;
                    #1 check("pready_drop_on_reset", DW'(pready[d]), '0);
                    for (int i = 0; i < ND; i++) begin
                        exp_ready[i] = 1'b0;
                        exp_rdata[i] = '0;
                    end
                    @(posedge PCLK); #1;
                    PRESET = 1'b1;
                    bus_idle();
                    return;
                end
                if (wr && !oob) begin
                    for (int b = 0; b < NB; b++)
                        if (se[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        PRESET = 1'b0;
        PWRITE = 1'b0;
        PADDR  = '0;
        PWDATA = '0;
        PSTRB  = '0;
        bus_idle();
        for (int i = 0; i < ND; i++) begin
            exp_err[i]   = 1'b0;
            exp_rdata[i] = '0;
        end
        repeat (3) @(posedge PCLK);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_pready[%0d]", d), DW'(pready[d]), '0);
            check($sformatf("rst_pslverr[%0d]", d), DW'(pslverr[d]), '0);
            check($sformatf("rst_prdata[%0d]", d), prdata[d], 32'h0000_0000);
        end
        PRESET = 1'b1;
        chk_on = 1'b1;

        // zero wait states, back-to-back write then read
        xfer(0, 1'b1, 10'h010, 32'hDEAD_BEEF, '1, -1, 1'b0);
        xfer(0, 1'b0, 10'h010, '0, '1, -1, 1'b0);
        check("w0_rd_ready", DW'(pready[0]), 32'd1);
        check("w0_rd_data", prdata[0], 32'hDEAD_BEEF);
        idle(1);

        // three wait states
        xfer(1, 1'b1, 10'h010, 32'hDEAD_BEEF, '1, -1, 1'b0);
        xfer(1, 1'b0, 10'h010, '0, '1, -1, 1'b0);
        check("w3_rd_data", prdata[1], 32'hDEAD_BEEF);
        check("w3_model_pin", exp_rdata[1], 32'hDEAD_BEEF);
        idle(1);

        // out-of-range accesses
        xfer(0, 1'b1, 10'h000, 32'hCAFE_F00D, '1, -1, 1'b0);
        xfer(0, 1'b1, 10'h100, 32'h1234_5678, '1, -1, 1'b0);
        check("oob_wr_err", DW'(pslverr[0]), 32'd1);
        xfer(0, 1'b0, 10'h100, '0, '1, -1, 1'b0);
        check("oob_rd_err", DW'(pslverr[0]), 32'd1);
        check("oob_rd_data", prdata[0], 32'h0);
        xfer(0, 1'b0, 10'h000, '0, '1, -1, 1'b0);
        check("idx0_kept", prdata[0], 32'hCAFE_F00D);
        xfer(0, 1'b0, 10'h3FF, '0, '1, -1, 1'b0);

        // same index back-to-back, misaligned read, write leaves PRDATA alone
        xfer(0, 1'b1, 10'h024, 32'h0BAD_F00D, '1, -1, 1'b0);
        xfer(0, 1'b0, 10'h027, '0, '1, -1, 1'b0);
        check("misaligned_rd", prdata[0], 32'h0BAD_F00D);
        xfer(0, 1'b1, 10'h028, 32'h7777_1111, '1, -1, 1'b0);
        check("wr_keeps_prdata", prdata[0], 32'h0BAD_F00D);

        // PENABLE without setup is ignored
        @(posedge PCLK); #1;
        bus_idle();
        psel[0] = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 10'h028;
        PWDATA  = 32'h5A5A_5A5A;
        idle(2);
        xfer(0, 1'b0, 10'h028, '0, '1, -1, 1'b0);
        check("stray_enable", prdata[0], 32'h7777_1111);
        idle(1);

        // aborts on the two-wait-state instance
        xfer(2, 1'b1, 10'h030, 32'h1111_2222, '1, -1, 1'b0);
        xfer(2, 1'b1, 10'h030, 32'h9999_9999, '1, 1, 1'b0);
        idle(1);
        xfer(2, 1'b1, 10'h030, 32'h5555_5555, '1, 2, 1'b0);
        xfer(2, 1'b0, 10'h030, '0, '1, -1, 1'b0);
        check("abort_no_write", prdata[2], 32'h1111_2222);
        idle(1);

        // reset during completion discards the write; memory survives reset
        xfer(1, 1'b1, 10'h040, 32'hAAAA_5555, '1, -1, 1'b0);
        xfer(1, 1'b1, 10'h040, 32'h0F0F_0F0F, '1, -1, 1'b1);
        idle(1);
        xfer(1, 1'b0, 10'h040, '0, '1, -1, 1'b0);
        check("rst_discards_write", prdata[1], 32'hAAAA_5555);
        xfer(1, 1'b0, 10'h010, '0, '1, -1, 1'b0);

`ifdef APB_MEM_SLAVE_PSTRB_EN
        xfer(0, 1'b1, 10'h020, 32'hFFFF_FFFF, 4'b1111, -1, 1'b0);
        xfer(0, 1'b1, 10'h020, 32'h0000_00AA, 4'b0001, -1, 1'b0);
        xfer(0, 1'b1, 10'h020, 32'h1234_5678, 4'b0000, -1, 1'b0);
        check("strb0_okay", DW'(pslverr[0]), 32'd0);
        xfer(0, 1'b0, 10'h020, '0, 4'b0000, -1, 1'b0);
        check("strb_merge", prdata[0], 32'hFFFF_FFAA);
`else
        xfer(0, 1'b1, 10'h020, 32'hFFFF_FFFF, 4'b1111, -1, 1'b0);
        xfer(0, 1'b1, 10'h020, 32'h0000_00AA, 4'b0001, -1, 1'b0);
        xfer(0, 1'b0, 10'h020, '0, 4'b0000, -1, 1'b0);
        check("full_word_write", prdata[0], 32'h0000_00AA);
`endif
        idle(2);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
